// File: rtl/reg_bank_sb.sv
// MIPS general-purpose register bank with writeback-to-read bypass and a pending-producer
// scoreboard that lets decode stall on RAW hazards.
module reg_bank_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] RR1,
  input  logic [ADDR_W-1:0] RR2,
  output logic [DATA_W-1:0] DR1,
  output logic [DATA_W-1:0] DR2,
  input  logic [ADDR_W-1:0] WR,
  input  logic [DATA_W-1:0] DW,
  input  logic              RegEn,
  input  logic              IssueEn,
  input  logic [ADDR_W-1:0] IssueReg,
  output logic              Busy1,
  output logic              Busy2,
  output logic              Stall,
  output logic [ADDR_W:0]   PendCount
);

  localparam int unsigned NumRegs  = 2 ** ADDR_W;
  localparam logic        ZeroHard = (ZERO_REG != 0);
  localparam logic [ADDR_W:0] CntOne = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0]  bank_q [NumRegs];
  logic [NumRegs-1:0] pend_q, pend_d;
  logic [ADDR_W:0]    cnt_q, cnt_d;

  logic wr_valid, iss_valid;
  logic rr1_zero, rr2_zero;
  logic rr1_hit, rr2_hit;
  logic cnt_inc, cnt_dec;

  assign wr_valid  = RegEn && !(ZeroHard && (WR == '0));
  assign iss_valid = IssueEn && !(ZeroHard && (IssueReg == '0));

  assign rr1_zero = ZeroHard && (RR1 == '0);
  assign rr2_zero = ZeroHard && (RR2 == '0);
  assign rr1_hit  = wr_valid && (WR == RR1);
  assign rr2_hit  = wr_valid && (WR == RR2);

  // Read ports: zero register first, then the in-flight writeback, then storage.
  always_comb begin
    DR1 = bank_q[RR1];
    if (rr1_zero) begin
      DR1 = '0;
    end else if (rr1_hit) begin
      DR1 = DW;
    end
  end

  always_comb begin
    DR2 = bank_q[RR2];
    if (rr2_zero) begin
      DR2 = '0;
    end else if (rr2_hit) begin
      DR2 = DW;
    end
  end

  // A same-cycle writeback satisfies the pending read.
  always_comb begin
    Busy1 = pend_q[RR1] && !rr1_hit && !rr1_zero;
    Busy2 = pend_q[RR2] && !rr2_hit && !rr2_zero;
    Stall = Busy1 || Busy2;
  end

  // Issue is applied after the clear so a new producer wins over a retiring one.
  always_comb begin
    pend_d = pend_q;
    if (wr_valid) begin
      pend_d[WR] = 1'b0;
    end
    if (iss_valid) begin
      pend_d[IssueReg] = 1'b1;
    end
  end

  always_comb begin
    cnt_inc = iss_valid && !pend_q[IssueReg];
    cnt_dec = wr_valid && pend_q[WR] && !(iss_valid && (IssueReg == WR));
    cnt_d   = cnt_q;
    unique case ({cnt_inc, cnt_dec})
      2'b10:   cnt_d = cnt_q + CntOne;
      2'b01:   cnt_d = cnt_q - CntOne;
      default: cnt_d = cnt_q;
    endcase
  end

  assign PendCount = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        bank_q[i] <= '0;
      end
    end else if (wr_valid) begin
      bank_q[WR] <= DW;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_reg_bank_sb.sv
// Self-checking bench for reg_bank_sb: array/popcount reference model checked every cycle,
// plus directed hand-computed checks for bypass, zero register, hazards, fill and reset.
`timescale 1ns/1ps
module tb_reg_bank_sb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  RR1, RR2, WR, IssueReg;
  logic [31:0] DW;
  logic        RegEn, IssueEn;
  logic [31:0] DR1, DR2;
  logic        Busy1, Busy2, Stall;
  logic [5:0]  PendCount;

  int n_chk;
  int n_fail;

  logic [31:0] mbank [32];
  logic        mpend [32];

  reg_bank_sb #(
    .DATA_W  (32),
    .ADDR_W  (5),
    .ZERO_REG(1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .RR1      (RR1),
    .RR2      (RR2),
    .DR1      (DR1),
    .DR2      (DR2),
    .WR       (WR),
    .DW       (DW),
    .RegEn    (RegEn),
    .IssueEn  (IssueEn),
    .IssueReg (IssueReg),
    .Busy1    (Busy1),
    .Busy2    (Busy2),
    .Stall    (Stall),
    .PendCount(PendCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, expressed directly from the read/busy/scoreboard rules.
  function automatic logic wvalid();
    return RegEn && (WR != 5'd0);
  endfunction

  function automatic logic [31:0] exp_dr(input logic [4:0] ra);
    if (ra == 5'd0) return 32'd0;
    if (wvalid() && WR == ra) return DW;
    return mbank[ra];
  endfunction

  function automatic logic exp_busy(input logic [4:0] ra);
    if (ra == 5'd0) return 1'b0;
    return mpend[ra] && !(wvalid() && WR == ra);
  endfunction

  function automatic int popcount();
    int c = 0;
    for (int i = 0; i < 32; i++) if (mpend[i]) c++;
    return c;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        mbank[i] <= 32'd0;
        mpend[i] <= 1'b0;
      end
    end else begin
      if (wvalid()) begin
        mbank[WR] <= DW;
        mpend[WR] <= 1'b0;
      end
      if (IssueEn && IssueReg != 5'd0) mpend[IssueReg] <= 1'b1;
    end
  end

  // Mid-cycle comparison against the model.
  always @(negedge clk) begin
    chk("model_dr1", DR1, exp_dr(RR1));
    chk("model_dr2", DR2, exp_dr(RR2));
    chk("model_busy1", {31'd0, Busy1}, {31'd0, exp_busy(RR1)});
    chk("model_busy2", {31'd0, Busy2}, {31'd0, exp_busy(RR2)});
    chk("model_stall", {31'd0, Stall}, {31'd0, exp_busy(RR1) | exp_busy(RR2)});
    chk("model_pendcount", {26'd0, PendCount}, popcount());
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegEn = 1'b0; IssueEn = 1'b0; WR = 5'd0; DW = 32'd0; IssueReg = 5'd0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    RR1 = 5'd0; RR2 = 5'd0;
    idle();
    #12 rst_n = 1'b1;
    step();

    // Write then read with bypass.
    RegEn = 1'b1; WR = 5'd5; DW = 32'hDEADBEEF; RR1 = 5'd5;
    #1 chk("bypass_r5", DR1, 32'hDEADBEEF);
    step();
    idle();
    #1 chk("stored_r5", DR1, 32'hDEADBEEF);

    // Zero register ignores writes and issues.
    RegEn = 1'b1; WR = 5'd0; DW = 32'h12345678; RR1 = 5'd0;
    IssueEn = 1'b1; IssueReg = 5'd0;
    #1 chk("r0_same_cycle", DR1, 32'd0);
    chk("r0_busy_same", {31'd0, Busy1}, 32'd0);
    step();
    idle();
    #1 chk("r0_next_cycle", DR1, 32'd0);
    chk("r0_pendcount", {26'd0, PendCount}, 32'd0);
    chk("r0_busy_next", {31'd0, Busy1}, 32'd0);

    // RAW hazard on r7.
    IssueEn = 1'b1; IssueReg = 5'd7;
    step();
    idle();
    RR2 = 5'd7;
    #1 chk("haz_busy2", {31'd0, Busy2}, 32'd1);
    chk("haz_stall", {31'd0, Stall}, 32'd1);
    chk("haz_pendcount", {26'd0, PendCount}, 32'd1);
    step();
    #1 chk("haz_still_busy", {31'd0, Busy2}, 32'd1);
    step();
    RegEn = 1'b1; WR = 5'd7; DW = 32'h000000A5;
    #1 chk("haz_wb_busy2", {31'd0, Busy2}, 32'd0);
    chk("haz_wb_dr2", DR2, 32'h000000A5);
    chk("haz_wb_stall", {31'd0, Stall}, 32'd0);
    step();
    idle();
    #1 chk("haz_cleared", {26'd0, PendCount}, 32'd0);
    chk("haz_dr2_stored", DR2, 32'h000000A5);

    // Simultaneous issue and writeback to a pending r9.
    IssueEn = 1'b1; IssueReg = 5'd9;
    step();
    RegEn = 1'b1; WR = 5'd9; DW = 32'h00000099; RR1 = 5'd9;
    #1 chk("sim_busy1", {31'd0, Busy1}, 32'd0);
    chk("sim_dr1", DR1, 32'h00000099);
    chk("sim_pend_before", {26'd0, PendCount}, 32'd1);
    step();
    idle();
    #1 chk("sim_pend_after", {26'd0, PendCount}, 32'd1);
    chk("sim_r9_busy", {31'd0, Busy1}, 32'd1);
    RegEn = 1'b1; WR = 5'd9; DW = 32'h0000009A;
    step();
    idle();
    #1 chk("sim_r9_clear", {26'd0, PendCount}, 32'd0);
    // Writeback to a non-pending register stays non-pending.
    RegEn = 1'b1; WR = 5'd4; DW = 32'h44;
    step();
    idle();
    #1 chk("wb_nonpend", {26'd0, PendCount}, 32'd0);

    // Fill the scoreboard.
    for (int r = 1; r < 32; r++) begin
      IssueEn = 1'b1; IssueReg = 5'(r);
      RR1 = 5'(r); RR2 = 5'(r - 1);
      step();
    end
    idle();
    #1 chk("fill_31", {26'd0, PendCount}, 32'd31);
    IssueEn = 1'b1; IssueReg = 5'd3;
    step();
    idle();
    #1 chk("fill_reissue", {26'd0, PendCount}, 32'd31);
    RegEn = 1'b1; WR = 5'd3; DW = 32'h33333333;
    step();
    idle();
    #1 chk("fill_wb_r3", {26'd0, PendCount}, 32'd30);

    // Mixed traffic: writes, issues and reads on varying registers.
    for (int i = 0; i < 24; i++) begin
      RegEn = (i % 3) != 0; WR = 5'((i * 7) % 32); DW = 32'h1000_0000 + 32'(i * 32'h0101);
      IssueEn = (i % 2) == 0; IssueReg = 5'((i * 5 + 3) % 32);
      RR1 = 5'((i * 7) % 32); RR2 = 5'((i * 3) % 32);
      step();
    end
    idle();
    RR1 = 5'd5; RR2 = 5'd3;
    step();

    // Asynchronous reset between edges with the bank loaded.
    rst_n = 1'b0;
    #0.1 chk("rst_pendcount", {26'd0, PendCount}, 32'd0);
    chk("rst_stall", {31'd0, Stall}, 32'd0);
    for (int a = 0; a < 32; a++) begin
      RR1 = 5'(a); RR2 = 5'(31 - a);
      #0.1;
      chk("rst_dr1", DR1, 32'd0);
      chk("rst_dr2", DR2, 32'd0);
    end
    step();
    step();
    #2 rst_n = 1'b1;
    step();
    RegEn = 1'b1; WR = 5'd6; DW = 32'h66; RR1 = 5'd6;
    step();
    idle();
    #1 chk("post_rst_write", DR1, 32'h66);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
